// File: rtl/coin_keypad_encoder.sv
// Coin/keypad front end: synchronize, debounce (when COIN_DEBOUNCE_EN is defined),
// rising-edge detect and prioritised event queueing toward the cafe FSM on x/x_valid/x_ready.
module coin_keypad_encoder #(
  parameter int DEB_CYCLES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin100_raw,
  input  logic       coin500_raw,
  input  logic       btn_expreso_raw,
  input  logic       btn_cancel_raw,
  input  logic       x_ready,
  output logic [2:0] x,
  output logic       x_valid,
  output logic       overflow,
  output logic [7:0] drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  if (DEB_CYCLES < 2 || DEB_CYCLES > 255 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("coin_keypad_encoder: DEB_CYCLES or FIFO_DEPTH out of range");
  end

  // Source bit order: 0 coin100, 1 coin500, 2 espresso, 3 cancel; event code = bit index + 1.
  logic [3:0]    w_raw;
  logic [3:0]    r_sync1, r_sync2, r_filt, r_filt_d, r_pend;
  logic [2:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic [7:0]    r_drop_cnt;

  logic [3:0]    w_rise, w_sel, w_drop;
  logic [2:0]    w_code, w_ndrop;
  logic [8:0]    w_drop_sum;
  logic          w_valid, w_pop, w_push, w_can_push;

  assign w_raw = {btn_cancel_raw, btn_expreso_raw, coin500_raw, coin100_raw};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_filt_d <= '0;
    end else begin
      r_sync1  <= w_raw;
      r_sync2  <= r_sync1;
      r_filt_d <= r_filt;
    end
  end

`ifdef COIN_DEBOUNCE_EN
  logic [7:0] r_cnt [4];

  // A differing sample must survive DEB_CYCLES further cycles before the level flips.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_filt <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == 8'(DEB_CYCLES)) begin
          r_filt[i] <= r_sync2[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_filt <= '0;
    else        r_filt <= r_sync2;
  end
`endif

  assign w_rise     = r_filt & ~r_filt_d;
  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid & x_ready;
  assign w_can_push = (r_count != (AW+1)'(FIFO_DEPTH)) | w_pop;

  always_comb begin
    w_sel  = '0;
    w_code = 3'b000;
    if (w_can_push) begin
      if (r_pend[1])      begin w_sel = 4'b0010; w_code = 3'b010; end
      else if (r_pend[0]) begin w_sel = 4'b0001; w_code = 3'b001; end
      else if (r_pend[2]) begin w_sel = 4'b0100; w_code = 3'b011; end
      else if (r_pend[3]) begin w_sel = 4'b1000; w_code = 3'b100; end
    end
  end

  // A pending bit being pushed this cycle is free again, so a coincident edge re-arms it.
  assign w_push     = |w_sel;
  assign w_drop     = w_rise & r_pend & ~w_sel;
  assign w_ndrop    = 3'(w_drop[0]) + 3'(w_drop[1]) + 3'(w_drop[2]) + 3'(w_drop[3]);
  assign w_drop_sum = 9'(r_drop_cnt) + 9'(w_ndrop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 3'b000;
    end else begin
      r_pend <= (r_pend & ~w_sel) | w_rise;
      if (w_push) begin
        r_mem[r_wptr] <= w_code;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (|w_drop) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= (w_drop_sum > 9'd255) ? 8'd255 : w_drop_sum[7:0];
      end
    end
  end

  assign x_valid  = w_valid;
  assign x        = w_valid ? r_mem[r_rptr] : 3'b000;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule
